// File: rtl/heartbeat_tx.sv
// Manchester heartbeat transmitter. It sends a free-running frame counter MSB first as SYNC, DATA, optional PARITY, then GAP.
// Define HEARTBEAT_PARITY_EN to add an even-parity bit after the data.
module heartbeat_tx #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIV      = 1,
  parameter int unsigned GAP      = 2,
  parameter int unsigned POLARITY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  output logic             signal,
  output logic             frame_start,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W    = $clog2(WIDTH);
  localparam int unsigned HB_W     = 5;
  localparam int unsigned DIV_LAST = DIV - 1;
  localparam int unsigned GAP_LAST = (GAP > 0) ? (2 * GAP - 1) : 0;
  localparam logic        POL      = 1'(POLARITY);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  localparam state_t AFTER_TX = (GAP > 0) ? S_GAP : S_IDLE;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [HB_W-1:0]    hb_q, hb_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               tick;
  logic               signal_d, frame_start_d, busy_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      idx_q       <= IDX_W'(WIDTH - 1);
      hb_q        <= '0;
      count_q     <= '0;
      signal      <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      hb_q        <= hb_d;
      count_q     <= count_d;
      signal      <= signal_d;
      frame_start <= frame_start_d;
      busy        <= busy_d;
    end
  end

  // Next-state: half-bit sequencing, divider and counter update
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    hb_d    = hb_q;
    count_d = count_q;
    tick    = (div_q == DIV_W'(DIV_LAST));
    if (state_q == S_IDLE) begin
      div_d = '0;
      hb_d  = '0;
      idx_d = IDX_W'(WIDTH - 1);
      if (ena) state_d = S_SYNC;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        hb_d = hb_q + 1'b1;
        case (state_q)
          S_SYNC: begin
            if (hb_q == HB_W'(3)) begin
              state_d = S_DATA;
              hb_d    = '0;
            end
          end
          S_DATA: begin
            if (hb_q[0]) begin
              hb_d = '0;
              if (idx_q == '0) begin
`ifdef HEARTBEAT_PARITY_EN
                state_d = S_PARITY;
`else
                state_d = AFTER_TX;
                count_d = count_q + 1'b1;
                idx_d   = IDX_W'(WIDTH - 1);
`endif
              end else begin
                idx_d = idx_q - 1'b1;
              end
            end
          end
`ifdef HEARTBEAT_PARITY_EN
          S_PARITY: begin
            if (hb_q[0]) begin
              hb_d    = '0;
              state_d = AFTER_TX;
              count_d = count_q + 1'b1;
              idx_d   = IDX_W'(WIDTH - 1);
            end
          end
`endif
          S_GAP: begin
            if (hb_q == HB_W'(GAP_LAST)) begin
              state_d = S_IDLE;
              hb_d    = '0;
            end
          end
          default: begin
            state_d = S_IDLE;
            hb_d    = '0;
          end
        endcase
      end
    end
  end

  // Output levels for the half-bit being entered; polarity never touches idle/gap
  always_comb begin
    signal_d      = 1'b0;
    frame_start_d = (state_q == S_IDLE) && ena;
    busy_d        = (state_d != S_IDLE);
    case (state_d)
      S_SYNC:   signal_d = ~hb_d[1] ^ POL;
      S_DATA:   signal_d = count_q[idx_d] ^ hb_d[0] ^ POL;
`ifdef HEARTBEAT_PARITY_EN
      S_PARITY: signal_d = (^count_q) ^ hb_d[0] ^ POL;
`endif
      default:  signal_d = 1'b0;
    endcase
  end

  assign count = count_q;

endmodule

// File: tb/tb_heartbeat_tx.sv
// Directed bench for heartbeat_tx: four instances cover base timing, wrap, divider and polarity.
// Expected waveforms come from a half-bit model of the frame format.
module tb_heartbeat_tx;

`ifdef HEARTBEAT_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena_a = 1'b0, ena_b = 1'b0, ena_c = 1'b0, ena_d = 1'b0;
  logic sig_a, fs_a, busy_a;
  logic sig_b, fs_b, busy_b;
  logic sig_c, fs_c, busy_c;
  logic sig_d, fs_d, busy_d;
  logic [7:0] cnt_a;
  logic [3:0] cnt_b, cnt_c, cnt_d;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  heartbeat_tx #(.WIDTH(8), .DIV(1), .GAP(2), .POLARITY(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .signal(sig_a),
    .frame_start(fs_a), .busy(busy_a), .count(cnt_a));
  heartbeat_tx #(.WIDTH(4), .DIV(1), .GAP(2), .POLARITY(0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .signal(sig_b),
    .frame_start(fs_b), .busy(busy_b), .count(cnt_b));
  heartbeat_tx #(.WIDTH(4), .DIV(3), .GAP(2), .POLARITY(0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .ena(ena_c), .signal(sig_c),
    .frame_start(fs_c), .busy(busy_c), .count(cnt_c));
  heartbeat_tx #(.WIDTH(4), .DIV(1), .GAP(1), .POLARITY(1)) u_pol (
    .clk(clk), .rst_n(rst_n), .ena(ena_d), .signal(sig_d),
    .frame_start(fs_d), .busy(busy_d), .count(cnt_d));

  // Expected line level at half-bit h of a frame carrying val
  function automatic logic model_half(input int w, input int pol, input int val, input int h);
    int   nd;
    int   np;
    int   k;
    logic d;
    logic par;
    logic b;
    nd  = 4 + 2 * w;
    np  = nd + 2 * P;
    par = 1'b0;
    for (int i = 0; i < w; i++) par = par ^ 1'((val >> i) & 1);
    if (h < 4) begin
      b = (h < 2);
    end else if (h < nd) begin
      k = (h - 4) / 2;
      d = 1'((val >> (w - 1 - k)) & 1);
      b = (((h - 4) % 2) == 0) ? d : ~d;
    end else if (h < np) begin
      b = ((h - nd) == 0) ? par : ~par;
    end else begin
      return 1'b0;
    end
    return b ^ 1'(pol);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({sig_a, fs_a, busy_a, cnt_a} !== 11'b0) begin
      fails++;
      $display("FAIL reset_a: got %b expected 0", {sig_a, fs_a, busy_a, cnt_a});
    end
    tests++;
    if ({sig_d, busy_d, cnt_b, cnt_c} !== 10'b0) begin
      fails++;
      $display("FAIL reset_others: got %b expected 0", {sig_d, busy_d, cnt_b, cnt_c});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if ({sig_a, fs_a, busy_a, cnt_a} !== 11'b0) begin
        fails++;
        $display("FAIL idle_no_ena cyc %0d: got %b expected 0", i, {sig_a, fs_a, busy_a, cnt_a});
      end
    end
  endtask

  // Runs frames first..last on u_dut with ena high, dropping ena early in the last one
  task automatic run_dut_frames(input int first, input int last);
    int len;
    len = 24 + 2 * P;
    ena_a = 1'b1;
    for (int f = first; f <= last; f++) begin
      for (int c = 0; c <= len; c++) begin
        @(negedge clk);
        tests++;
        if (sig_a !== ((c < len) ? model_half(8, 0, f, c) : 1'b0)) begin
          fails++;
          $display("FAIL dut_signal f=%0d c=%0d: got %b", f, c, sig_a);
        end
        tests++;
        if (fs_a !== (c == 0) || busy_a !== (c < len)) begin
          fails++;
          $display("FAIL dut_fs_busy f=%0d c=%0d: got fs=%b busy=%b", f, c, fs_a, busy_a);
        end
`ifdef HEARTBEAT_PARITY_EN
        if ((f == 3 || f == 7) && (c == 20 || c == 21)) begin
          tests++;
          if (sig_a !== ((f == 7) ^ (c == 21))) begin
            fails++;
            $display("FAIL parity_bit f=%0d c=%0d: got %b", f, c, sig_a);
          end
        end
`endif
        if (c == 0) begin
          tests++;
          if (cnt_a !== 8'(f)) begin
            fails++;
            $display("FAIL dut_count_in_frame f=%0d: got %0d expected %0d", f, cnt_a, f);
          end
          if (f == last) ena_a = 1'b0;
        end
        if (c == len) begin
          tests++;
          if (cnt_a !== 8'(f + 1)) begin
            fails++;
            $display("FAIL dut_count_after f=%0d: got %0d expected %0d", f, cnt_a, f + 1);
          end
        end
      end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if ({sig_a, fs_a, busy_a} !== 3'b0) begin
        fails++;
        $display("FAIL dut_rest_idle cyc %0d: got %b expected 000", i, {sig_a, fs_a, busy_a});
      end
    end
  endtask

  task automatic test_first_frames();
    run_dut_frames(0, 1);
  endtask

  task automatic test_counting();
    run_dut_frames(2, 7);
  endtask

  task automatic test_wrap();
    int len;
    len = 16 + 2 * P;
    ena_b = 1'b1;
    for (int f = 0; f <= 16; f++) begin
      for (int c = 0; c <= len; c++) begin
        @(negedge clk);
        tests++;
        if (sig_b !== ((c < len) ? model_half(4, 0, f % 16, c) : 1'b0)) begin
          fails++;
          $display("FAIL wrap_signal f=%0d c=%0d: got %b", f, c, sig_b);
        end
        tests++;
        if (fs_b !== (c == 0)) begin
          fails++;
          $display("FAIL wrap_spacing f=%0d c=%0d: fs got %b", f, c, fs_b);
        end
        if (c == 0) begin
          tests++;
          if (cnt_b !== 4'(f % 16)) begin
            fails++;
            $display("FAIL wrap_count f=%0d: got %0d expected %0d", f, cnt_b, f % 16);
          end
          if (f == 16) ena_b = 1'b0;
        end
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (busy_b !== 1'b0 || cnt_b !== 4'd1) begin
      fails++;
      $display("FAIL wrap_end: got busy=%b count=%0d expected busy=0 count=1", busy_b, cnt_b);
    end
  endtask

  task automatic test_div3();
    int len;
    len = 3 * (16 + 2 * P);
    ena_c = 1'b1;
    for (int f = 0; f <= 1; f++) begin
      for (int c = 0; c <= len; c++) begin
        @(negedge clk);
        tests++;
        if (sig_c !== ((c < len) ? model_half(4, 0, f, c / 3) : 1'b0)) begin
          fails++;
          $display("FAIL div3_signal f=%0d c=%0d: got %b", f, c, sig_c);
        end
        tests++;
        if (fs_c !== (c == 0) || busy_c !== (c < len)) begin
          fails++;
          $display("FAIL div3_fs_busy f=%0d c=%0d: got fs=%b busy=%b", f, c, fs_c, busy_c);
        end
        if (c == 0) begin
          tests++;
          if (cnt_c !== 4'(f)) begin
            fails++;
            $display("FAIL div3_count f=%0d: got %0d expected %0d", f, cnt_c, f);
          end
          if (f == 1) ena_c = 1'b0;
        end
      end
    end
  endtask

  task automatic test_polarity();
    int len;
    len = 14 + 2 * P;
    ena_d = 1'b1;
    for (int c = 0; c <= len + 3; c++) begin
      @(negedge clk);
      if (c == 0) ena_d = 1'b0;
      tests++;
      if (sig_d !== ((c < len) ? model_half(4, 1, 0, c) : 1'b0)) begin
        fails++;
        $display("FAIL pol_signal c=%0d: got %b", c, sig_d);
      end
    end
    tests++;
    if (cnt_d !== 4'd1 || busy_d !== 1'b0) begin
      fails++;
      $display("FAIL pol_end: got count=%0d busy=%b expected 1,0", cnt_d, busy_d);
    end
  endtask

  task automatic test_reset_mid();
    ena_a = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      tests++;
      if (sig_a !== model_half(8, 0, 8, c)) begin
        fails++;
        $display("FAIL pre_reset c=%0d: got %b", c, sig_a);
      end
    end
    @(posedge clk);
    #2;
    tests++;
    if (sig_a !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_high: got %b expected 1", sig_a);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sig_a, fs_a, busy_a, cnt_a} !== 11'b0) begin
      fails++;
      $display("FAIL async_reset: got %b expected 0", {sig_a, fs_a, busy_a, cnt_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_dut_frames(0, 0);
  endtask

  initial begin
    test_reset();
    test_first_frames();
    test_counting();
    test_wrap();
    test_div3();
    test_polarity();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/heartbeat_tx.md
# heartbeat_tx

Parametrised Manchester-encoded heartbeat transmitter for per-cell liveness monitoring. It continuously transmits a free-running frame counter on a single output pin, MSB first. Each frame is framed by a sync violation and followed by an idle gap, and the rate is programmable. A scope or logic analyser on the cell's output decodes cell alive-ness and clock health without any host interaction.

## Interface
- `WIDTH`, 8: frame counter width in bits; legal range 2..32.
- `DIV`, 1: clock cycles per Manchester half-bit; legal range 1..256.
- `GAP`, 2: idle bit periods between frames; legal range 0..15.
- `POLARITY`, 0: 0 sends data bit 1 as high-then-low; 1 inverts `signal` during SYNC and DATA/PARITY only, never during idle/gap.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  frame enable, sampled only in IDLE.
- `signal`  out  1  registered Manchester line output.
- `frame_start`  out  1  one-cycle pulse, coincident with the first SYNC half-bit on `signal`.
- `busy`  out  1  high in SYNC, DATA, PARITY and GAP.
- `count`  out  WIDTH  counter value being (or next to be) transmitted.

## Operation
- Reset, asynchronous: `signal`=0, `frame_start`=0, `busy`=0, `count`=0, state IDLE, divider=0, bit index=WIDTH-1, half-bit phase=0.
- Half-bit tick: an internal divider counts 0..DIV-1; the tick fires when it reaches DIV-1. The divider restarts at 0 on every frame start.
- States:
  - IDLE: `signal`=0. At an edge with `ena`=1, go to SYNC, drive the first SYNC level and pulse `frame_start`.
  - SYNC: 4 half-bits, levels H,H,L,L. This is a deliberate Manchester violation. Then go to DATA.
  - DATA: WIDTH bits, from `count[WIDTH-1]` down to `count[0]`. Each bit is 2 half-bits: first half = bit, second half = ~bit (before POLARITY). After the last bit, go to PARITY if compiled in, else GAP.
  - PARITY: optional, see Configuration.
  - GAP: 2*GAP half-bits at `signal`=0. With GAP=0 the state lasts zero half-bits and goes straight to IDLE.
- Counter update: `count` increments by 1 at the tick ending the final data/parity half-bit. It wraps from all-ones to 0. `count` is stable for the whole frame.
- `ena` deasserted mid-frame: the frame, including its GAP, completes normally; the block then rests in IDLE.
- `ena` held high: IDLE lasts exactly one cycle between frames.

## Timing
- Latency: `ena` sampled high in IDLE at edge N gives `signal`/`frame_start` valid after edge N. `frame_start` is high for exactly one cycle.
- Frame length in clocks: DIV*(4 + 2*WIDTH + 2*P + 2*GAP), where P=1 if parity is compiled in, else P=0.
- Frame-start period with `ena` high: that frame length + 1 clock.
- `signal` is glitch-free because it comes directly from a flop.
- `busy` falls on the edge that enters IDLE.
- Reset mid-frame: `signal` goes to 0 immediately. No partial frame resumes, and `count` restarts at 0.

## Configuration
- `HEARTBEAT_PARITY_EN` defined: a PARITY state follows DATA. It sends one Manchester bit equal to the even parity (XOR) of the WIDTH data bits, so that data plus parity has an even count of ones.
- Undefined: no PARITY state, P=0. Frame length and period shrink by 2*DIV clocks.

## Test plan
- Reset, WIDTH=8 DIV=1 GAP=2, `ena`=0 → `signal`=0, `busy`=0, `count`=0 indefinitely.
- Raise `ena` → `frame_start` is a 1-cycle pulse. `signal` = 1,1,0,0 then 0x00 as 16 half-bits 0,1,…,0,1, then 4 low. `count` reads 1 after the frame. The next frame sends 0x01 with a final pair of 1,0.
- WIDTH=4 with `ena` held high → 16 frames send 0x0..0xF, then 0x0. The wrap is verified, and the frame_start spacing is 4+8+4+1=17 clocks.
- DIV=3 → every half-bit lasts exactly 3 cycles, and the frame_start spacing is 3*16+1=49 clocks for WIDTH=4 GAP=2.
- `HEARTBEAT_PARITY_EN`, WIDTH=8, frame with `count`=0x07 → parity bit 1 is sent as 1,0 after the data. With `count`=0x03 it is sent as 0,1.
- `rst_n` pulsed low during DATA → `signal`=0 asynchronously. After release with `ena`=1, the next frame sends 0x00. Dropping `ena` mid-frame completes the frame and gap, then stays IDLE.
